pc_predict_unit: RTL
====================

# pc_predict_unit

Fetch-side PC selection and prediction unit for the pipelined Y86-64 core, replacing the purely combinational next-PC logic of the sequential design. It holds the predicted-PC register, selects the actual fetch PC from the redirect sources, and predicts the next PC. Jumps and calls are predicted taken. Returns are predicted from a parametrised return-address stack (RAS). The unit also latches a committed halt so that fetch freezes.

## Interface
- `ADDR_W`, 64: width of all PC/value buses.
- `RAS_DEPTH`, 8: number of RAS entries (≥2).
- `RESET_PC`, 0: predicted PC after reset.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `f_stall`  in  1  fetch stall from hazard control; holds all state.
- `f_icode`  in  4  icode of instruction fetched at `f_pc`.
- `f_valC`  in  ADDR_W  constant/destination of fetched instruction.
- `f_valP`  in  ADDR_W  fall-through address of fetched instruction.
- `m_icode`  in  4  memory-stage icode.
- `m_cnd`  in  1  memory-stage condition result.
- `m_valA`  in  ADDR_W  memory-stage valA (fall-through of a jXX).
- `w_valid`  in  1  writeback stage holds a real (non-bubble) instruction.
- `w_icode`  in  4  writeback-stage icode.
- `w_valM`  in  ADDR_W  writeback-stage valM (return address of ret).
- `f_pc`  out  ADDR_W  PC to fetch this cycle (combinational).
- `pred_pc`  out  ADDR_W  registered predicted PC.
- `ret_hit`  out  1  current fetch is ret and the RAS is non-empty (combinational).
- `ras_count`  out  $clog2(RAS_DEPTH+1)  valid RAS entries.
- `halted`  out  1  sticky committed-halt flag.

## Operation
- Icode encodings: HALT=0, JXX=7, CALL=8, RET=9.
- `f_pc` select, in priority order:
  - `m_icode==JXX && !m_cnd` → `m_valA` (mispredicted branch).
  - Otherwise `w_valid && w_icode==RET` → `w_valM`.
  - Otherwise → `pred_pc`.
- Next prediction, from `f_icode`:
  - JXX or CALL → `f_valC`.
  - RET with `ras_count>0` → RAS top (`ret_hit`=1).
  - RET with empty RAS → `f_valP` (`ret_hit`=0).
  - Any other icode → `f_valP`.
- accept = `!f_stall && !halted`. On accept, `pred_pc` ← next prediction. Otherwise `pred_pc` holds.
- RAS is a circular buffer with a top pointer and a saturating count.
  - CALL accepted: push `f_valP`. If full, the oldest entry is overwritten and the count stays at `RAS_DEPTH`.
  - RET accepted: pop. Empty pop is a no-op and the count stays at 0.
  - No push or pop when not accepted.
  - A push and a pop can never coincide (single icode).
- The RAS is not repaired on redirect. Wrong-path pushes and pops persist; a wrong RAS top costs only performance, because every ret still redirects from W.
- `halted` is set when `w_valid && w_icode==HALT`. It clears only on reset. While `halted` is 1: `pred_pc` and the RAS freeze, and `f_pc` still obeys the select rules.
- `rst_n`=0 at an edge, including mid-stream:
  - `pred_pc`=`RESET_PC`, `ras_count`=0, `halted`=0, pointer=0.
  - RAS contents don't matter.
  - Reset overrides stall and halt.

## Timing
- `f_pc`, `ret_hit`: combinational from inputs and state, same cycle.
- `pred_pc`, `ras_count`, `halted`: one-cycle latency, updated at the edge after the qualifying input.
- A redirect at edge k means the instruction at the redirect target is fetched in cycle k's `f_pc`. Its prediction appears in `pred_pc` after edge k.
- The RAS top reflects a push from edge k-1 at cycle k (call followed immediately by ret predicts correctly).
- Reset values during and after reset: `f_pc`=`RESET_PC` (absent redirects), `pred_pc`=`RESET_PC`, `ret_hit`=0, `ras_count`=0, `halted`=0.

## Test plan
- Reset, then fetch nops with `f_valP`=PC+1 → `pred_pc` steps 0,1,2,…. Then assert `f_stall` for 3 cycles → `pred_pc` holds.
- Fetch CALL (`f_valC`=0x100, `f_valP`=0x0A), then RET next cycle → `ras_count` 1 then 0. At RET `ret_hit`=1, and `pred_pc`=0x0A after the RET edge.
- With `RAS_DEPTH`=8, do 9 calls with valP 1..9, then 9 rets.
  - Predictions: 9,8,…,2.
  - The 9th ret has `ret_hit`=0 and predicts its `f_valP`.
  - `ras_count` peaks at 8 and ends at 0.
- Simultaneous `m_icode`=7, `m_cnd`=0, `m_valA`=0x40 and `w_icode`=RET, `w_valM`=0x80 → `f_pc`=0x40. With `m_cnd`=1 → `f_pc`=0x80.
- `w_valid`=1, `w_icode`=0 → `halted`=1 the next cycle. `pred_pc` and `ras_count` stay frozen for 5 cycles despite CALL on `f_icode`. Pulse `rst_n` low → all outputs return to reset values.
- Push 3 calls, then assert `rst_n`=0 alongside a CALL → `ras_count`=0, RET then gives `ret_hit`=0.

Source files
------------

// File: rtl/pc_predict_unit.sv
// Fetch-side PC selection and next-PC prediction for the pipelined Y86-64 core.
// Holds the predicted-PC register, picks the actual fetch PC from the redirect
// sources, predicts jumps/calls taken, predicts returns from a circular
// return-address stack and latches a committed halt so that fetch freezes.
module pc_predict_unit #(
  parameter int                ADDR_W    = 64,
  parameter int                RAS_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           f_stall,
  input  logic [3:0]                     f_icode,
  input  logic [ADDR_W-1:0]              f_valC,
  input  logic [ADDR_W-1:0]              f_valP,
  input  logic [3:0]                     m_icode,
  input  logic                           m_cnd,
  input  logic [ADDR_W-1:0]              m_valA,
  input  logic                           w_valid,
  input  logic [3:0]                     w_icode,
  input  logic [ADDR_W-1:0]              w_valM,
  output logic [ADDR_W-1:0]              f_pc,
  output logic [ADDR_W-1:0]              pred_pc,
  output logic                           ret_hit,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           halted
);

  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  localparam logic [3:0] ICODE_HALT = 4'h0;
  localparam logic [3:0] ICODE_JXX  = 4'h7;
  localparam logic [3:0] ICODE_CALL = 4'h8;
  localparam logic [3:0] ICODE_RET  = 4'h9;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RAS_DEPTH - 1);

  // ptr is the slot the next push writes; the top of stack sits one below it.
  // When the stack is full, ptr also names the oldest entry, so a push there
  // naturally overwrites the oldest return address.
  logic [ADDR_W-1:0] ras [RAS_DEPTH];
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  top_idx;
  logic [PTR_W-1:0]  next_ptr;
  logic [ADDR_W-1:0] next_pred;
  logic              accept;
  logic              ras_empty;
  logic              push;
  logic              pop;

  assign ras_empty = (ras_count == '0);
  assign accept    = !f_stall && !halted;
  assign push      = accept && (f_icode == ICODE_CALL);
  assign pop       = accept && (f_icode == ICODE_RET) && !ras_empty;
  assign ret_hit   = (f_icode == ICODE_RET) && !ras_empty;
  assign top_idx   = (ptr == '0) ? PTR_LAST : ptr - PTR_W'(1);
  assign next_ptr  = (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);

  // Fetch PC: a mispredicted branch outranks a committed ret, else use the prediction.
  always_comb begin
    f_pc = pred_pc;
    if ((m_icode == ICODE_JXX) && !m_cnd) begin
      f_pc = m_valA;
    end else if (w_valid && (w_icode == ICODE_RET)) begin
      f_pc = w_valM;
    end
  end

  // Next-PC prediction from the instruction being fetched this cycle.
  always_comb begin
    next_pred = f_valP;
    case (f_icode)
      ICODE_JXX, ICODE_CALL: next_pred = f_valC;
      ICODE_RET:             next_pred = ras_empty ? f_valP : ras[top_idx];
      default:               next_pred = f_valP;
    endcase
  end

  // Prediction register, RAS bookkeeping and sticky halt; reset wins over stall and halt.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pred_pc   <= RESET_PC;
      ras_count <= '0;
      ptr       <= '0;
      halted    <= 1'b0;
    end else begin
      if (accept) begin
        pred_pc <= next_pred;
      end
      if (push) begin
        ptr <= next_ptr;
        if (ras_count != CNT_FULL) begin
          ras_count <= ras_count + CNT_W'(1);
        end
      end else if (pop) begin
        ptr       <= top_idx;
        ras_count <= ras_count - CNT_W'(1);
      end
      if (w_valid && (w_icode == ICODE_HALT)) begin
        halted <= 1'b1;
      end
    end
  end

  // RAS storage; contents are don't-care after reset, so no reset is applied.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      ras[ptr] <= f_valP;
    end
  end

endmodule
